hscale_seq: RTL and testbench
=============================

Name: hscale_seq

Overview:
- Horizontal-scaler sequencer that drives one pixel interpolator per colour channel from a dual-read line buffer.
- For each output pixel it steps a fixed-point source position and issues two buffer read addresses plus the interpolation fraction.
- It also generates the aligned blank/valid timing for the interpolator output.
- Sits between the line-buffer write side (rotation/scaler path) and the video output mixer.

Parameters:
- AW, 10, width of source/destination pixel indices and widths.
- FW, 8, fraction width; must equal the interpolator fracwidth.
- RD_LAT, 1, line-buffer read latency in cycles (≥1).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- line_start  in  1  one-cycle pulse that starts (or restarts) a line.
- src_width  in  AW  source pixels available in the buffer; sampled on line_start.
- dst_width  in  AW  output pixels to generate; sampled on line_start.
- step  in  AW+FW  source increment per output pixel, unsigned fixed point (src/dst); sampled on line_start.
- phase  in  FW  initial fractional position; sampled on line_start.
- rd_en  out  1  read strobe for both buffer ports.
- rd_addr_a  out  AW  index feeding the interpolator "in" input (weight 1−frac).
- rd_addr_b  out  AW  index feeding the interpolator "in_prev" input (weight frac).
- frac  out  FW  interpolation fraction.
- blank  out  1  drives the interpolator blank input.
- out_valid  out  1  interpolator output is a real pixel this cycle.
- out_x  out  AW  destination index of the valid pixel.
- busy  out  1  line in progress, including drain.
- line_done  out  1  one-cycle pulse after the last valid pixel.

Behaviour:
- Reset (reset_n=0 at a clk edge) takes effect from the next cycle:
  - state IDLE
  - rd_en=0, rd_addr_a=0, rd_addr_b=0, frac=0
  - blank=1, out_valid=0, out_x=0, busy=0, line_done=0
  - all delay stages cleared
- Reset mid-line abandons the line; no line_done is produced.
- State machine: IDLE, RUN, DRAIN.
- IDLE + line_start:
  - latch src_width, dst_width, step
  - pos ← {0, phase}, a fixed-point register of AW+FW bits; x ← 0
  - next state RUN, or DRAIN directly if dst_width=0
- RUN, each cycle:
  - idx = pos integer part; f = pos fraction
  - if idx ≥ src_width−1: rd_addr_a = rd_addr_b = src_width−1 and frac = 0 (edge replicate)
  - else: rd_addr_a = idx, rd_addr_b = idx+1, frac = f
  - rd_en=1; pos += step, saturating at the all-ones value (no wrap); x++
  - after issuing x = dst_width−1, go to DRAIN
- Outputs rd_en/rd_addr_* are registered, i.e. they appear in the cycle after the state/pos that produced them (cycle T).
- frac alignment:
  - frac must reach the interpolator one cycle before its sample pair.
  - frac is therefore delayed RD_LAT−1 cycles relative to the address (0 extra for RD_LAT=1).
- Output alignment:
  - out_valid, out_x and ~blank for the pixel addressed in cycle T appear in cycle T+RD_LAT+2.
  - They are produced by a shift pipeline carrying {valid, x}.
  - blank = ~out_valid.
- DRAIN:
  - waits until the pipeline is empty, then pulses line_done in the cycle after the last out_valid.
  - returns to IDLE, which clears busy.
  - for dst_width=0: DRAIN lasts one cycle, then line_done.
- line_start while busy: abort and restart.
  - The valid pipeline is flushed (no out_valid for the old line, no old line_done).
  - Parameters are re-latched and RUN begins the same as from IDLE.
- busy: high from the cycle after line_start through the line_done cycle.
- src_width=0 is treated as 1: all addresses 0, frac 0.
- Width rules:
  - the pos+step sum is computed at AW+FW+1 bits, then saturated
  - frac is exactly FW bits
  - out_x is AW bits

Decomposition:
- Shared package: the state enum (IDLE/RUN/DRAIN) and the FW/AW defaults, so the interpolator instances and this block use identical fraction widths.
- One sub-module, hscale_dly: a parameterised width/depth register delay line with synchronous clear. It is used for the frac delay (depth RD_LAT−1; depth 0 means passthrough) and for the {valid,x} pipeline (depth RD_LAT+2).

Test Plan:
- Identity scale: src=4, dst=4, step=256, phase=0.
  - Required: rd_addr_a 0,1,2,3; rd_addr_b 1,2,3,3; frac 0 each.
  - Required: out_valid for 4 cycles starting 3 cycles after the first rd_en; out_x 0..3; line_done the next cycle.
- 2× upscale: src=4, dst=8, step=128.
  - Required: rd_addr_a 0,0,1,1,2,2,3,3; frac 0,128,0,128,0,128,0,0 (last two edge-clamped); rd_addr_b 1,1,2,2,3,3,3,3.
- Phase and saturation: phase=64, step=0x3FF_FF with AW=10.
  - Required: first frac 64; second access clamped to src_width−1 with frac 0; no address wrap to 0.
- dst_width=0: line_start produces no rd_en and no out_valid; line_done exactly 2 cycles after line_start; busy high for those cycles only.
- Abort: line_start again at the 3rd RUN cycle of a dst=8 line.
  - Required: no out_valid carrying old-line x beyond what had already exited; a new out_x sequence 0..7; exactly one line_done.
- Reset mid-RUN: reset_n=0 for one cycle.
  - Required: next cycle busy=0, blank=1, rd_en=0, no line_done; a subsequent line_start behaves as from power-up.

Source files
------------

// File: rtl/hscale_seq_pkg.sv
// Shared definitions for the horizontal scaler sequencer and its interpolators.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The interpolator instances import HS_FW so both sides always agree on the fraction width.
package hscale_seq_pkg;

    localparam int HS_AW = 10;  // pixel index / width bits
    localparam int HS_FW = 8;   // interpolation fraction bits

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } hs_state_t;

endpackage

// File: rtl/hscale_dly.sv
// Register delay line of W bits by D cycles with synchronous clear; D=0 is a wire.
// Latency: D cycles.
// Backpressure: none, the line shifts every cycle.
// Ports: clk, reset_n (sync, active low), clr (empties every stage), in_dat -> out_dat.
module hscale_dly #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic [W-1:0] in_dat,
    output logic [W-1:0] out_dat
);

    if (D == 0) begin : g_pass
        logic unused_ctl;
        assign unused_ctl = ^{clk, reset_n, clr};
        assign out_dat    = in_dat;
    end else begin : g_pipe
        logic [D-1:0][W-1:0] stage_q;
        logic [D-1:0][W-1:0] stage_d;

        always_comb begin
            stage_d    = stage_q;
            stage_d[0] = in_dat;
            for (int i = 1; i < D; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            if (clr) begin
                stage_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign out_dat = stage_q[D-1];
    end

endmodule

// File: rtl/hscale_seq.sv
// Horizontal scaler sequencer: steps a fixed-point source position per output pixel, issuing two line-buffer reads plus fraction.
// Latency: read strobe/addresses one cycle after the position; out_valid/out_x RD_LAT+2 cycles after the read strobe.
// Backpressure: none; line_start at any time aborts the current line and restarts.
// Ports: line_start/src_width/dst_width/step/phase in; rd_en/rd_addr_a/rd_addr_b/frac to buffer and interpolator;
//        blank/out_valid/out_x aligned to the interpolator output; busy/line_done line status.
module hscale_seq
    import hscale_seq_pkg::*;
#(
    parameter int AW     = HS_AW,
    parameter int FW     = HS_FW,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             line_start,
    input  logic [AW-1:0]    src_width,
    input  logic [AW-1:0]    dst_width,
    input  logic [AW+FW-1:0] step,
    input  logic [FW-1:0]    phase,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr_a,
    output logic [AW-1:0]    rd_addr_b,
    output logic [FW-1:0]    frac,
    output logic             blank,
    output logic             out_valid,
    output logic [AW-1:0]    out_x,
    output logic             busy,
    output logic             line_done
);

    localparam int PW        = AW + FW;
    localparam int DRAIN_CYC = RD_LAT + 2;
    localparam int CW        = $clog2(DRAIN_CYC + 1);

    hs_state_t      state_q, state_d;
    logic [AW-1:0]  src_w_q, src_w_d;
    logic [AW-1:0]  dst_w_q, dst_w_d;
    logic [PW-1:0]  step_q, step_d;
    logic [PW-1:0]  pos_q, pos_d;
    logic [AW-1:0]  x_q, x_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rd_en_q, rd_en_d;
    logic [AW-1:0]  addr_a_q, addr_a_d;
    logic [AW-1:0]  addr_b_q, addr_b_d;
    logic [FW-1:0]  frac_q, frac_d;
    logic [AW-1:0]  ox_q, ox_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [AW-1:0]  idx;
    logic [AW-1:0]  src_last;
    logic [PW:0]    pos_sum;
    logic           flush;
    logic [AW:0]    vld_out;

    assign idx      = pos_q[PW-1:FW];
    // A zero-width source behaves like a single pixel at index 0.
    assign src_last = (src_w_q == '0) ? '0 : src_w_q - 1'b1;
    assign pos_sum  = {1'b0, pos_q} + {1'b0, step_q};
    // Restarting over a live line must drop everything still in flight.
    assign flush    = line_start && (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        src_w_d  = src_w_q;
        dst_w_d  = dst_w_q;
        step_d   = step_q;
        pos_d    = pos_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        rd_en_d  = 1'b0;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        frac_d   = frac_q;
        ox_d     = '0;
        done_d   = 1'b0;

        if (line_start) begin
            src_w_d = src_width;
            dst_w_d = dst_width;
            step_d  = step;
            pos_d   = {{AW{1'b0}}, phase};
            x_d     = '0;
            cnt_d   = '0;
            state_d = (dst_width == '0) ? ST_DRAIN : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    rd_en_d = 1'b1;
                    ox_d    = x_q;
                    if (idx >= src_last) begin
                        // Past the right edge: replicate the last source pixel.
                        addr_a_d = src_last;
                        addr_b_d = src_last;
                        frac_d   = '0;
                    end else begin
                        addr_a_d = idx;
                        addr_b_d = idx + 1'b1;
                        frac_d   = pos_q[FW-1:0];
                    end
                    pos_d = pos_sum[PW] ? {PW{1'b1}} : pos_sum[PW-1:0];
                    x_d   = x_q + 1'b1;
                    if (x_q == dst_w_q - 1'b1) begin
                        state_d = ST_DRAIN;
                        // The last read needs this many cycles to leave the valid pipeline.
                        cnt_d   = CW'(DRAIN_CYC);
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // busy covers the line_done cycle even though the FSM is already idle.
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            src_w_q  <= '0;
            dst_w_q  <= '0;
            step_q   <= '0;
            pos_q    <= '0;
            x_q      <= '0;
            cnt_q    <= '0;
            rd_en_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            frac_q   <= '0;
            ox_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_w_q  <= src_w_d;
            dst_w_q  <= dst_w_d;
            step_q   <= step_d;
            pos_q    <= pos_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            rd_en_q  <= rd_en_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            frac_q   <= frac_d;
            ox_q     <= ox_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The interpolator wants frac one cycle ahead of its sample pair.
    hscale_dly #(.W(FW), .D(RD_LAT - 1)) u_frac_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .in_dat  (frac_q),
        .out_dat (frac)
    );

    hscale_dly #(.W(AW + 1), .D(RD_LAT + 2)) u_vld_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .in_dat  ({rd_en_q, ox_q}),
        .out_dat (vld_out)
    );

    assign rd_en     = rd_en_q;
    assign rd_addr_a = addr_a_q;
    assign rd_addr_b = addr_b_q;
    assign out_valid = vld_out[AW];
    assign out_x     = vld_out[AW-1:0];
    assign blank     = ~vld_out[AW];
    assign busy      = busy_q;
    assign line_done = done_q;

endmodule

// File: tb/tb_hscale_seq.sv
module tb_hscale_seq;

    localparam int AW     = 10;
    localparam int FW     = 8;
    localparam int RD_LAT = 1;
    localparam int PW     = AW + FW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          line_start = 1'b0;
    logic [AW-1:0] src_width = '0;
    logic [AW-1:0] dst_width = '0;
    logic [PW-1:0] step = '0;
    logic [FW-1:0] phase = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [FW-1:0] frac;
    logic          blank;
    logic          out_valid;
    logic [AW-1:0] out_x;
    logic          busy;
    logic          line_done;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int blank_bad = 0;

    hscale_seq #(.AW(AW), .FW(FW), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .src_width  (src_width),
        .dst_width  (dst_width),
        .step       (step),
        .phase      (phase),
        .rd_en      (rd_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .frac       (frac),
        .blank      (blank),
        .out_valid  (out_valid),
        .out_x      (out_x),
        .busy       (busy),
        .line_done  (line_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled mid-cycle and tagged with the cycle number.
    typedef struct { int cyc; int a; int b; int f; } rd_ev_t;
    typedef struct { int cyc; int x; } v_ev_t;
    rd_ev_t rd_log[$];
    v_ev_t  v_log[$];
    int     done_log[$];
    int     busy_log[$];

    always @(negedge clk) begin
        if (rd_en === 1'b1) rd_log.push_back('{cyc: cyc, a: int'(rd_addr_a), b: int'(rd_addr_b), f: int'(frac)});
        if (out_valid === 1'b1) v_log.push_back('{cyc: cyc, x: int'(out_x)});
        if (line_done === 1'b1) done_log.push_back(cyc);
        if (busy === 1'b1) busy_log.push_back(cyc);
        if (blank !== ~out_valid) blank_bad <= blank_bad + 1;
    end

    // Reference: output pixel k samples source position min(phase + k*step, max), clamped at the right edge.
    function automatic void model_rd(input int src, input int k, input int st, input int ph,
                                     output int a, output int b, output int f);
        longint p  = longint'(ph) + longint'(k) * longint'(st);
        longint mx = (longint'(1) << PW) - 1;
        int     s1 = (src == 0) ? 0 : src - 1;
        int     ip;
        if (p > mx) p = mx;
        ip = int'(p >> FW);
        if (ip >= s1) begin
            a = s1; b = s1; f = 0;
        end else begin
            a = ip; b = ip + 1; f = int'(p % (longint'(1) << FW));
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        v_log.delete();
        done_log.delete();
        busy_log.delete();
    endtask

    task automatic start_line(input int s, input int d, input int st, input int ph, output int c);
        src_width  = AW'(s);
        dst_width  = AW'(d);
        step       = PW'(st);
        phase      = FW'(ph);
        line_start = 1'b1;
        c          = cyc;
        tick();
        line_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr_a, rd_addr_b, frac} !== '0) begin
            n_fail++;
            $display("FAIL reset_rd: got en=%0d a=%0d b=%0d f=%0d want all 0", rd_en, rd_addr_a, rd_addr_b, frac);
        end
        n_checks++;
        if (blank !== 1'b1 || out_valid !== 1'b0 || out_x !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got blank=%0d vld=%0d x=%0d want 1 0 0", blank, out_valid, out_x);
        end
        n_checks++;
        if (busy !== 1'b0 || line_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got busy=%0d done=%0d want 0 0", busy, line_done);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        int c;
        int ea[4] = '{0, 1, 2, 3};
        int eb[4] = '{1, 2, 3, 3};
        clear_logs();
        start_line(4, 4, 256, 0, c);
        repeat (12) tick();
        n_checks++;
        if (rd_log.size() != 4) begin
            n_fail++;
            $display("FAIL identity_rd_count: got %0d want 4", rd_log.size());
        end
        foreach (rd_log[k]) begin
            if (k < 4) begin
                n_checks++;
                if (rd_log[k].cyc != c + 2 + k || rd_log[k].a != ea[k] || rd_log[k].b != eb[k] || rd_log[k].f != 0) begin
                    n_fail++;
                    $display("FAIL identity_rd%0d: got cyc=%0d a=%0d b=%0d f=%0d want cyc=%0d a=%0d b=%0d f=0",
                             k, rd_log[k].cyc - c, rd_log[k].a, rd_log[k].b, rd_log[k].f, 2 + k, ea[k], eb[k]);
                end
            end
        end
        n_checks++;
        if (v_log.size() != 4) begin
            n_fail++;
            $display("FAIL identity_vld_count: got %0d want 4", v_log.size());
        end
        foreach (v_log[k]) begin
            n_checks++;
            if (v_log[k].cyc != c + 2 + 3 + k || v_log[k].x != k) begin
                n_fail++;
                $display("FAIL identity_vld%0d: got cyc=%0d x=%0d want cyc=%0d x=%0d",
                         k, v_log[k].cyc - c, v_log[k].x, 5 + k, k);
            end
        end
        n_checks++;
        if (done_log.size() != 1 || done_log[0] != c + 9) begin
            n_fail++;
            $display("FAIL identity_done: got count=%0d want one pulse at +9", done_log.size());
        end
        n_checks++;
        if (busy_log.size() != 9 || busy_log[0] != c + 1 || busy_log[8] != c + 9) begin
            n_fail++;
            $display("FAIL identity_busy: got %0d cycles want 9 from +1 to +9", busy_log.size());
        end
    endtask

    task automatic test_upscale();
        int c;
        int ea[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int eb[8] = '{1, 1, 2, 2, 3, 3, 3, 3};
        int ef[8] = '{0, 128, 0, 128, 0, 128, 0, 0};
        clear_logs();
        start_line(4, 8, 128, 0, c);
        repeat (16) tick();
        n_checks++;
        if (rd_log.size() != 8) begin
            n_fail++;
            $display("FAIL upscale_rd_count: got %0d want 8", rd_log.size());
        end
        foreach (rd_log[k]) begin
            if (k < 8) begin
                n_checks++;
                if (rd_log[k].a != ea[k] || rd_log[k].b != eb[k] || rd_log[k].f != ef[k]) begin
                    n_fail++;
                    $display("FAIL upscale_rd%0d: got a=%0d b=%0d f=%0d want a=%0d b=%0d f=%0d",
                             k, rd_log[k].a, rd_log[k].b, rd_log[k].f, ea[k], eb[k], ef[k]);
                end
            end
        end
        n_checks++;
        if (v_log.size() != 8 || done_log.size() != 1) begin
            n_fail++;
            $display("FAIL upscale_out: got %0d valid %0d done want 8 valid 1 done", v_log.size(), done_log.size());
        end
    endtask

    task automatic test_saturate();
        int c;
        clear_logs();
        start_line(8, 3, 18'h3FFFF, 64, c);
        repeat (12) tick();
        n_checks++;
        if (rd_log.size() != 3) begin
            n_fail++;
            $display("FAIL sat_rd_count: got %0d want 3", rd_log.size());
        end else begin
            n_checks++;
            if (rd_log[0].a != 0 || rd_log[0].b != 1 || rd_log[0].f != 64) begin
                n_fail++;
                $display("FAIL sat_first: got a=%0d b=%0d f=%0d want 0 1 64", rd_log[0].a, rd_log[0].b, rd_log[0].f);
            end
            for (int k = 1; k < 3; k++) begin
                n_checks++;
                if (rd_log[k].a != 7 || rd_log[k].b != 7 || rd_log[k].f != 0) begin
                    n_fail++;
                    $display("FAIL sat_clamp%0d: got a=%0d b=%0d f=%0d want 7 7 0", k, rd_log[k].a, rd_log[k].b, rd_log[k].f);
                end
            end
        end
    endtask

    task automatic test_dst_zero();
        int c;
        clear_logs();
        start_line(5, 0, 256, 0, c);
        repeat (8) tick();
        n_checks++;
        if (rd_log.size() != 0 || v_log.size() != 0) begin
            n_fail++;
            $display("FAIL dst0_activity: got %0d reads %0d valid want 0 0", rd_log.size(), v_log.size());
        end
        n_checks++;
        if (done_log.size() != 1 || done_log[0] != c + 2) begin
            n_fail++;
            $display("FAIL dst0_done: got count=%0d want one pulse at +2", done_log.size());
        end
        n_checks++;
        if (busy_log.size() != 2 || busy_log[0] != c + 1) begin
            n_fail++;
            $display("FAIL dst0_busy: got %0d cycles want 2 from +1", busy_log.size());
        end
    endtask

    task automatic test_abort();
        int c1, c2, n_new, a, b, f;
        clear_logs();
        start_line(4, 8, 128, 0, c1);
        tick();
        tick();
        start_line(4, 8, 128, 0, c2);
        repeat (18) tick();
        n_new = 0;
        foreach (rd_log[k]) begin
            if (rd_log[k].cyc > c2) begin
                model_rd(4, n_new, 128, 0, a, b, f);
                n_checks++;
                if (rd_log[k].cyc != c2 + 2 + n_new || rd_log[k].a != a || rd_log[k].b != b || rd_log[k].f != f) begin
                    n_fail++;
                    $display("FAIL abort_rd%0d: got cyc=%0d a=%0d b=%0d f=%0d want cyc=%0d a=%0d b=%0d f=%0d",
                             n_new, rd_log[k].cyc - c2, rd_log[k].a, rd_log[k].b, rd_log[k].f, 2 + n_new, a, b, f);
                end
                n_new++;
            end
        end
        n_checks++;
        if (n_new != 8 || v_log.size() != 8) begin
            n_fail++;
            $display("FAIL abort_count: got %0d reads %0d valid want 8 8", n_new, v_log.size());
        end
        foreach (v_log[k]) begin
            n_checks++;
            if (v_log[k].cyc != c2 + 4 + RD_LAT + k || v_log[k].x != k) begin
                n_fail++;
                $display("FAIL abort_vld%0d: got cyc=%0d x=%0d want cyc=%0d x=%0d",
                         k, v_log[k].cyc - c2, v_log[k].x, 4 + RD_LAT + k, k);
            end
        end
        n_checks++;
        if (done_log.size() != 1 || done_log[0] != c2 + 4 + RD_LAT + 8) begin
            n_fail++;
            $display("FAIL abort_done: got count=%0d want one pulse at +%0d", done_log.size(), 12 + RD_LAT);
        end
    endtask

    task automatic test_reset_mid();
        int c, a, b, f;
        start_line(4, 8, 128, 0, c);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_logs();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || blank !== 1'b1 || rd_en !== 1'b0 || line_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got busy=%0d blank=%0d rd_en=%0d done=%0d want 0 1 0 0",
                     busy, blank, rd_en, line_done);
        end
        tick();
        repeat (14) tick();
        n_checks++;
        if (done_log.size() != 0 || v_log.size() != 0 || rd_log.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d done %0d valid %0d reads want 0 0 0",
                     done_log.size(), v_log.size(), rd_log.size());
        end
        clear_logs();
        start_line(3, 5, 200, 10, c);
        repeat (14) tick();
        n_checks++;
        if (rd_log.size() != 5 || v_log.size() != 5 || done_log.size() != 1 || done_log[0] != c + 4 + RD_LAT + 5) begin
            n_fail++;
            $display("FAIL midreset_restart: got %0d reads %0d valid %0d done want 5 5 1", rd_log.size(), v_log.size(), done_log.size());
        end
        foreach (rd_log[k]) begin
            model_rd(3, k, 200, 10, a, b, f);
            n_checks++;
            if (rd_log[k].a != a || rd_log[k].b != b || rd_log[k].f != f) begin
                n_fail++;
                $display("FAIL midreset_rd%0d: got a=%0d b=%0d f=%0d want %0d %0d %0d", k, rd_log[k].a, rd_log[k].b, rd_log[k].f, a, b, f);
            end
        end
    endtask

    task automatic test_random();
        int c, s, d, st, ph, a, b, f, done_at, bad;
        for (int n = 0; n < 16; n++) begin
            s  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 1023));
            d  = int'($urandom_range(0, 20));
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << PW) - 1)) : int'($urandom_range(16, 600));
            ph = int'($urandom_range(0, 255));
            clear_logs();
            start_line(s, d, st, ph, c);
            repeat (d + RD_LAT + 8) tick();
            done_at = (d == 0) ? c + 2 : c + 4 + RD_LAT + d;
            n_checks++;
            if (rd_log.size() != d || v_log.size() != d) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d reads %0d valid want %0d (src=%0d step=%0d)",
                         n, rd_log.size(), v_log.size(), d, s, st);
            end
            bad = 0;
            foreach (rd_log[k]) begin
                model_rd(s, k, st, ph, a, b, f);
                if (rd_log[k].cyc != c + 2 + k || rd_log[k].a != a || rd_log[k].b != b || rd_log[k].f != f) begin
                    if (bad == 0)
                        $display("FAIL rand%0d_rd%0d: got cyc=%0d a=%0d b=%0d f=%0d want cyc=%0d a=%0d b=%0d f=%0d",
                                 n, k, rd_log[k].cyc - c, rd_log[k].a, rd_log[k].b, rd_log[k].f, 2 + k, a, b, f);
                    bad++;
                end
            end
            foreach (v_log[k]) begin
                if (v_log[k].cyc != c + 4 + RD_LAT + k || v_log[k].x != k) begin
                    if (bad == 0)
                        $display("FAIL rand%0d_vld%0d: got cyc=%0d x=%0d want cyc=%0d x=%0d",
                                 n, k, v_log[k].cyc - c, v_log[k].x, 4 + RD_LAT + k, k);
                    bad++;
                end
            end
            n_checks++;
            if (bad != 0) n_fail++;
            n_checks++;
            if (done_log.size() != 1 || done_log[0] != done_at ||
                busy_log.size() != done_at - c || busy_log[0] != c + 1) begin
                n_fail++;
                $display("FAIL rand%0d_status: got %0d done %0d busy cycles want 1 done %0d busy (dst=%0d)",
                         n, done_log.size(), busy_log.size(), done_at - c, d);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_upscale();
        test_saturate();
        test_dst_zero();
        test_abort();
        test_reset_mid();
        test_random();
        n_checks++;
        if (blank_bad != 0) begin
            n_fail++;
            $display("FAIL blank_vs_valid: got %0d cycles with blank == out_valid want 0", blank_bad);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
